regfile_sequencer: RTL and testbench

REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

---
 rtl/regfile_sequencer.sv | 172 +++++++++++++++++
 tb/tb_regfile_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sequencer.sv
// Purpose : sequences one register-file operation (read, ALU execute, write back) per start request.
// Latency : start sampled at edge k -> READ, EXEC, WRITE (we) in cycle k+3, done pulse in cycle k+4.
// Backpress: none queued; start is only looked at in IDLE, requests while busy are dropped.
//
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   start, op, dst, srca,
//   srcb, imm               : operation request and its operands (latched in IDLE)
//   R_Adr/R, S_Adr/S        : register-file read ports (data combinational from address)
//   W_Adr, we, W            : register-file write port
//   busy, done              : status; done is a one-cycle completion pulse
//   result, zf, nf, cf      : last computed value and its flags, held until the next EXEC
module regfile_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [2:0]  dst,
    input  logic [2:0]  srca,
    input  logic [2:0]  srcb,
    input  logic [15:0] imm,
    output logic [2:0]  W_Adr,
    output logic [2:0]  R_Adr,
    output logic [2:0]  S_Adr,
    output logic        we,
    output logic [15:0] W,
    input  logic [15:0] R,
    input  logic [15:0] S,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        zf,
    output logic        nf,
    output logic        cf
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [2:0] OP_MOV = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_LDI = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    state_t      state_q, state_d;
    logic [2:0]  op_q,   op_d;
    logic [2:0]  dst_q,  dst_d;
    logic [2:0]  srca_q, srca_d;
    logic [2:0]  srcb_q, srcb_d;
    logic [15:0] imm_q,  imm_d;
    logic [15:0] a_q,    a_d;
    logic [15:0] b_q,    b_d;
    logic [15:0] result_q, result_d;
    logic        zf_q, zf_d;
    logic        nf_q, nf_d;
    logic        cf_q, cf_d;

    // 17-bit ALU output; bit 16 is carry for ADD and borrow for SUB/CMP.
    logic [16:0] y;

    always_comb begin
        y = 17'd0;
        case (op_q)
            OP_MOV: y = {1'b0, a_q};
            OP_ADD: y = {1'b0, a_q} + {1'b0, b_q};
            OP_SUB: y = {1'b0, a_q} - {1'b0, b_q};
            OP_AND: y = {1'b0, a_q & b_q};
            OP_OR:  y = {1'b0, a_q | b_q};
            OP_XOR: y = {1'b0, a_q ^ b_q};
            OP_LDI: y = {1'b0, imm_q};
            OP_CMP: y = {1'b0, a_q} - {1'b0, b_q};
            default: y = 17'd0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        dst_d    = dst_q;
        srca_d   = srca_q;
        srcb_d   = srcb_q;
        imm_d    = imm_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        zf_d     = zf_q;
        nf_d     = nf_q;
        cf_d     = cf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = op;
                    dst_d   = dst;
                    srca_d  = srca;
                    srcb_d  = srcb;
                    imm_d   = imm;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                // Operands are captured before the write-back, so dst==src
                // always sees the pre-write value.
                a_d     = R;
                b_d     = S;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                result_d = y[15:0];
                zf_d     = (y[15:0] == 16'd0);
                nf_d     = y[15];
                // Bit 16 is zero for the logical ops, MOV and LDI by construction.
                cf_d     = y[16];
                state_d  = ST_WRITE;
            end
            ST_WRITE: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= 3'd0;
            dst_q    <= 3'd0;
            srca_q   <= 3'd0;
            srcb_q   <= 3'd0;
            imm_q    <= 16'd0;
            a_q      <= 16'd0;
            b_q      <= 16'd0;
            result_q <= 16'd0;
            zf_q     <= 1'b0;
            nf_q     <= 1'b0;
            cf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            dst_q    <= dst_d;
            srca_q   <= srca_d;
            srcb_q   <= srcb_d;
            imm_q    <= imm_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            zf_q     <= zf_d;
            nf_q     <= nf_d;
            cf_q     <= cf_d;
        end
    end

    assign R_Adr  = srca_q;
    assign S_Adr  = srcb_q;
    assign W_Adr  = (state_q == ST_WRITE) ? dst_q : 3'd0;
    assign we     = (state_q == ST_WRITE) && (op_q != OP_CMP);
    assign W      = result_q;
    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign zf     = zf_q;
    assign nf     = nf_q;
    assign cf     = cf_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
module tb_regfile_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [2:0]  dst;
    logic [2:0]  srca;
    logic [2:0]  srcb;
    logic [15:0] imm;
    logic [2:0]  W_Adr;
    logic [2:0]  R_Adr;
    logic [2:0]  S_Adr;
    logic        we;
    logic [15:0] W;
    logic [15:0] R;
    logic [15:0] S;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        zf;
    logic        nf;
    logic        cf;

    int checks = 0;
    int errors = 0;

    // Simple 8x16 register file attached to the sequencer.
    logic [15:0] regs [8];
    assign R = regs[R_Adr];
    assign S = regs[S_Adr];
    always @(posedge clk) begin
        if (we) regs[W_Adr] <= W;
    end

    regfile_sequencer dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .dst    (dst),
        .srca   (srca),
        .srcb   (srcb),
        .imm    (imm),
        .W_Adr  (W_Adr),
        .R_Adr  (R_Adr),
        .S_Adr  (S_Adr),
        .we     (we),
        .W      (W),
        .R      (R),
        .S      (S),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zf     (zf),
        .nf     (nf),
        .cf     (cf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issues one operation at a negedge in IDLE and checks every cycle of it.
    // Returns at the negedge after the operation has gone back to IDLE.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [2:0] d,
                          input logic [2:0] sa, input logic [2:0] sb, input logic [15:0] im,
                          input logic exp_we, input logic [15:0] exp_w);
        start = 1'b1; op = o; dst = d; srca = sa; srcb = sb; imm = im;
        @(negedge clk);                         // after edge k: READ
        start = 1'b0; op = 3'd0; dst = 3'd0; srca = 3'd0; srcb = 3'd0; imm = 16'd0;
        check({tag, ".read_busy"}, 32'(busy), 32'd1);
        check({tag, ".read_radr"}, 32'(R_Adr), 32'(sa));
        check({tag, ".read_sadr"}, 32'(S_Adr), 32'(sb));
        check({tag, ".read_we"},   32'(we), 32'd0);
        @(negedge clk);                         // EXEC
        check({tag, ".exec_we"},   32'(we), 32'd0);
        check({tag, ".exec_done"}, 32'(done), 32'd0);
        @(negedge clk);                         // WRITE (cycle k+3)
        check({tag, ".wr_we"},     32'(we), 32'(exp_we));
        check({tag, ".wr_wadr"},   32'(W_Adr), 32'(d));
        check({tag, ".wr_w"},      32'(W), 32'(exp_w));
        check({tag, ".wr_done"},   32'(done), 32'd0);
        @(negedge clk);                         // DONE (cycle k+4)
        check({tag, ".done"},      32'(done), 32'd1);
        check({tag, ".done_we"},   32'(we), 32'd0);
        check({tag, ".done_wadr"}, 32'(W_Adr), 32'd0);
        @(negedge clk);                         // back in IDLE
        check({tag, ".idle_busy"}, 32'(busy), 32'd0);
        check({tag, ".idle_done"}, 32'(done), 32'd0);
    endtask

    task automatic check_flags(input string tag, input logic z, input logic n, input logic c);
        check({tag, ".zf"}, 32'(zf), 32'(z));
        check({tag, ".nf"}, 32'(nf), 32'(n));
        check({tag, ".cf"}, 32'(cf), 32'(c));
    endtask

    initial begin
        int done_cnt;
        int we_cnt;
        int first_done;
        int second_done;

        for (int i = 0; i < 8; i++) regs[i] = 16'hDEAD;
        reset = 1'b1; start = 1'b0; op = 3'd0; dst = 3'd0;
        srca = 3'd0; srcb = 3'd0; imm = 16'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst.busy",   32'(busy), 32'd0);
        check("rst.done",   32'(done), 32'd0);
        check("rst.we",     32'(we), 32'd0);
        check("rst.wadr",   32'(W_Adr), 32'd0);
        check("rst.radr",   32'(R_Adr), 32'd0);
        check("rst.result", 32'(result), 32'd0);
        check_flags("rst", 1'b0, 1'b0, 1'b0);

        // start=0 keeps IDLE
        @(negedge clk);
        check("idle.busy", 32'(busy), 32'd0);

        // LDI r3 = 0x1234
        run_op("ldi3", 3'b110, 3'd3, 3'd0, 3'd0, 16'h1234, 1'b1, 16'h1234);
        check("ldi3.reg", 32'(regs[3]), 32'h1234);
        check("ldi3.result", 32'(result), 32'h1234);
        check_flags("ldi3", 1'b0, 1'b0, 1'b0);

        // ADD with carry out: 0xFFFF + 0x0001 -> 0x0000 into r4
        run_op("ldi1", 3'b110, 3'd1, 3'd0, 3'd0, 16'hFFFF, 1'b1, 16'hFFFF);
        check_flags("ldi1", 1'b0, 1'b1, 1'b0);
        run_op("ldi2", 3'b110, 3'd2, 3'd0, 3'd0, 16'h0001, 1'b1, 16'h0001);
        run_op("add", 3'b001, 3'd4, 3'd1, 3'd2, 16'h0000, 1'b1, 16'h0000);
        check("add.reg4", 32'(regs[4]), 32'h0000);
        check_flags("add", 1'b1, 1'b0, 1'b1);

        // SUB with borrow, dst == srca: r1 = 1 - 2 = 0xFFFF
        run_op("ldi1b", 3'b110, 3'd1, 3'd0, 3'd0, 16'h0001, 1'b1, 16'h0001);
        run_op("ldi2b", 3'b110, 3'd2, 3'd0, 3'd0, 16'h0002, 1'b1, 16'h0002);
        run_op("sub", 3'b010, 3'd1, 3'd1, 3'd2, 16'h0000, 1'b1, 16'hFFFF);
        check("sub.reg1", 32'(regs[1]), 32'hFFFF);
        check_flags("sub", 1'b0, 1'b1, 1'b1);

        // XOR: 0xFFFF ^ 0x1234 = 0xEDCB into r6, carry cleared
        run_op("xor", 3'b101, 3'd6, 3'd1, 3'd3, 16'h0000, 1'b1, 16'hEDCB);
        check("xor.reg6", 32'(regs[6]), 32'hEDCB);
        check_flags("xor", 1'b0, 1'b1, 1'b0);

        // CMP equal operands: no write, zf=1, r7 untouched
        run_op("ldi5", 3'b110, 3'd5, 3'd0, 3'd0, 16'h5A5A, 1'b1, 16'h5A5A);
        run_op("ldi6", 3'b110, 3'd6, 3'd0, 3'd0, 16'h5A5A, 1'b1, 16'h5A5A);
        run_op("cmp", 3'b111, 3'd7, 3'd5, 3'd6, 16'h0000, 1'b0, 16'h0000);
        check("cmp.reg7", 32'(regs[7]), 32'hDEAD);
        check("cmp.reg5", 32'(regs[5]), 32'h5A5A);
        check_flags("cmp", 1'b1, 1'b0, 1'b0);

        // start held for 10 cycles: MOV r0 <- r3, accepted at k and k+5 only
        done_cnt = 0; we_cnt = 0; first_done = -1; second_done = -1;
        start = 1'b1; op = 3'b000; dst = 3'd0; srca = 3'd3; srcb = 3'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);                     // sample after edge k+i
            if (done) begin
                done_cnt++;
                if (first_done < 0) first_done = i;
                else if (second_done < 0) second_done = i;
            end
            if (we) we_cnt++;
        end
        start = 1'b0;
        check("hold.busy_end", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (we) we_cnt++;
        end
        check("hold.done_cnt", 32'(done_cnt), 32'd2);
        check("hold.we_cnt", 32'(we_cnt), 32'd2);
        check("hold.first_done", 32'(first_done), 32'd3);
        check("hold.second_done", 32'(second_done), 32'd8);
        check("hold.reg0", 32'(regs[0]), 32'h1234);

        // Reset during EXEC of an ADD abandons it
        run_op("ldi7", 3'b110, 3'd7, 3'd0, 3'd0, 16'h00AA, 1'b1, 16'h00AA);
        start = 1'b1; op = 3'b001; dst = 3'd4; srca = 3'd3; srcb = 3'd7;
        @(negedge clk);                         // READ
        start = 1'b0;
        @(negedge clk);                         // EXEC
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstx.busy", 32'(busy), 32'd0);
        check("rstx.result", 32'(result), 32'd0);
        check("rstx.we", 32'(we), 32'd0);
        check("rstx.done", 32'(done), 32'd0);
        check("rstx.radr", 32'(R_Adr), 32'd0);
        done_cnt = 0; we_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (we) we_cnt++;
        end
        check("rstx.no_done", 32'(done_cnt), 32'd0);
        check("rstx.no_we", 32'(we_cnt), 32'd0);
        check("rstx.reg4", 32'(regs[4]), 32'h0000);

        // Reset wins over start in the same cycle
        start = 1'b1; op = 3'b110; dst = 3'd2; imm = 16'h7777; reset = 1'b1;
        @(negedge clk);
        start = 1'b0; reset = 1'b0;
        check("rstprio.busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
